// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver with break-before-make dead time, illegal-command fault latch and optional low-side brake.
// Optional feature: define HBRIDGE_BRAKE_EN to resolve an OFF command to BRAKE instead of coasting in IDLE.
module hbridge_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                motor_positive,
    input  logic                motor_negative,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault_clear,
    output logic                high_a,
    output logic                low_a,
    output logic                high_b,
    output logic                low_b,
    output logic                fault,
    output logic [7:0]          fault_count,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_POS   = 3'd2,
        ST_NEG   = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [1:0] CMD_OFF = 2'b00;
    localparam logic [1:0] CMD_NEG = 2'b01;
    localparam logic [1:0] CMD_POS = 2'b10;
    localparam logic [1:0] CMD_BAD = 2'b11;

    // Gate vector order: {high_a, low_a, high_b, low_b}
    localparam logic [3:0] GATES_OFF   = 4'b0000;
    localparam logic [3:0] GATES_POS   = 4'b1001;
    localparam logic [3:0] GATES_NEG   = 4'b0110;
    localparam logic [3:0] GATES_BRAKE = 4'b0101;

`ifdef HBRIDGE_BRAKE_EN
    localparam state_t OFF_STATE = ST_BRAKE;
`else
    localparam state_t OFF_STATE = ST_IDLE;
`endif

    state_t                state_q, state_d;
    logic [1:0]            cmd_q;
    logic [1:0]            target_q, target_d;
    logic [DT_WIDTH-1:0]   counter_q, counter_d;
    logic [3:0]            gates_q, gates_d;
    logic                  fault_q, fault_d;
    logic [7:0]            count_q, count_d;
    logic [DT_WIDTH-1:0]   dt_load;
    logic [1:0]            drive;
    logic                  overlap;

    function automatic state_t resolve(input logic [1:0] tgt);
        case (tgt)
            CMD_POS: resolve = ST_POS;
            CMD_NEG: resolve = ST_NEG;
            default: resolve = OFF_STATE;
        endcase
    endfunction

    always_comb begin
        dt_load = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;
        case (state_q)
            ST_POS:  drive = CMD_POS;
            ST_NEG:  drive = CMD_NEG;
            default: drive = CMD_OFF;
        endcase
        overlap = (gates_q[3] & gates_q[2]) | (gates_q[1] & gates_q[0]);
    end

    // Fault handling outranks the enable gate, which outranks normal sequencing.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        counter_d = counter_q;
        fault_d   = fault_q;
        count_d   = count_q;

        if (state_q == ST_FAULT) begin
            if (fault_clear && cmd_q == CMD_OFF) begin
                state_d = ST_IDLE;
                fault_d = 1'b0;
            end
        end else if (cmd_q == CMD_BAD || overlap) begin
            state_d   = ST_FAULT;
            fault_d   = 1'b1;
            counter_d = '0;
            count_d   = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
        end else if (!enable) begin
            state_d   = ST_IDLE;
            counter_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_POS, ST_NEG, ST_BRAKE: begin
                    if (cmd_q != drive) begin
                        state_d   = ST_DEAD;
                        target_d  = cmd_q;
                        counter_d = dt_load;
                    end
                end
                ST_DEAD: begin
                    // A new command restarts the full dead interval.
                    if (cmd_q != target_q) begin
                        target_d  = cmd_q;
                        counter_d = dt_load;
                    end else if (counter_q <= DT_WIDTH'(1)) begin
                        state_d   = resolve(target_q);
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        case (state_d)
            ST_POS:   gates_d = GATES_POS;
            ST_NEG:   gates_d = GATES_NEG;
            ST_BRAKE: gates_d = GATES_BRAKE;
            default:  gates_d = GATES_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= CMD_OFF;
            state_q   <= ST_IDLE;
            target_q  <= CMD_OFF;
            counter_q <= '0;
            gates_q   <= GATES_OFF;
            fault_q   <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            cmd_q     <= {motor_positive, motor_negative};
            state_q   <= state_d;
            target_q  <= target_d;
            counter_q <= counter_d;
            gates_q   <= gates_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
        end
    end

    assign {high_a, low_a, high_b, low_b} = gates_q;
    assign fault       = fault_q;
    assign fault_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Directed scoreboard bench for hbridge_deadtime: expected per-edge outputs are queued, then popped and compared.
// Honours HBRIDGE_BRAKE_EN when choosing the expected OFF resolution.
module tb_hbridge_deadtime;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       motor_positive;
    logic       motor_negative;
    logic [7:0] dead_time;
    logic       fault_clear;
    logic       high_a, low_a, high_b, low_b;
    logic       fault;
    logic [7:0] fault_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] G_OFF = 4'b0000;
    localparam logic [3:0] G_POS = 4'b1001;
    localparam logic [3:0] G_NEG = 4'b0110;
`ifdef HBRIDGE_BRAKE_EN
    localparam logic [2:0] S_OFFEND = 3'd4;
    localparam logic [3:0] G_OFFEND = 4'b0101;
`else
    localparam logic [2:0] S_OFFEND = 3'd0;
    localparam logic [3:0] G_OFFEND = 4'b0000;
`endif

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [3:0] gates;
        logic       flt;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    hbridge_deadtime #(.DT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .motor_positive (motor_positive),
        .motor_negative (motor_negative),
        .dead_time      (dead_time),
        .fault_clear    (fault_clear),
        .high_a         (high_a),
        .low_a          (low_a),
        .high_b         (high_b),
        .low_b          (low_b),
        .fault          (fault),
        .fault_count    (fault_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic mp, input logic mn, input logic en,
                                 input logic fc, input logic [7:0] dt);
        motor_positive = mp;
        motor_negative = mn;
        enable         = en;
        fault_clear    = fc;
        dead_time      = dt;
    endtask

    task automatic pushExp(input string tag, input logic [2:0] st, input logic [3:0] g,
                           input logic f, input logic [7:0] c);
        exp_t e;
        e.tag = tag; e.st = st; e.gates = g; e.flt = f; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [3:0] g;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            g = {high_a, low_a, high_b, low_b};
            checks++;
            assert (state === e.st) else begin
                errors++;
                $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
            end
            checks++;
            assert (g === e.gates) else begin
                errors++;
                $error("FAIL %s gates: observed %b expected %b", e.tag, g, e.gates);
            end
            checks++;
            assert (fault === e.flt) else begin
                errors++;
                $error("FAIL %s fault: observed %b expected %b", e.tag, fault, e.flt);
            end
            checks++;
            assert (fault_count === e.cnt) else begin
                errors++;
                $error("FAIL %s fault_count: observed %0d expected %0d", e.tag, fault_count, e.cnt);
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        #1;
        pushExp("reset", 3'd0, G_OFF, 1'b0, 8'd0);
        checkOutput();
        #2 reset = 1'b0;
        pushExp("idle", 3'd0, G_OFF, 1'b0, 8'd0);
        pushExp("idle", 3'd0, G_OFF, 1'b0, 8'd0);
        runCycles(2);

        $display("[TB] dead_time=4 forward start");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
        pushExp("pos_e0", 3'd0, G_OFF, 1'b0, 8'd0);
        for (int i = 1; i <= 4; i++) pushExp("pos_dead", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("pos_e5", 3'd2, G_POS, 1'b0, 8'd0);
        pushExp("pos_hold", 3'd2, G_POS, 1'b0, 8'd0);
        runCycles(7);

        $display("[TB] POS to NEG swap, dead_time=3");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
        pushExp("swap_e0", 3'd2, G_POS, 1'b0, 8'd0);
        for (int i = 1; i <= 3; i++) pushExp("swap_dead", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("swap_e4", 3'd3, G_NEG, 1'b0, 8'd0);
        runCycles(5);

        $display("[TB] enable dropped in NEG");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        pushExp("en_drop", 3'd0, G_OFF, 1'b0, 8'd0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        pushExp("en_low", 3'd0, G_OFF, 1'b0, 8'd0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        pushExp("en_back", 3'd0, G_OFF, 1'b0, 8'd0);
        runCycles(1);

        $display("[TB] dead_time=0 treated as 1");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        pushExp("dt0_e0", 3'd0, G_OFF, 1'b0, 8'd0);
        pushExp("dt0_e1", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("dt0_e2", 3'd2, G_POS, 1'b0, 8'd0);
        runCycles(3);

        $display("[TB] POS to OFF, dead_time=2");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        pushExp("off_e0", 3'd2, G_POS, 1'b0, 8'd0);
        pushExp("off_dead", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("off_dead", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("off_e3", S_OFFEND, G_OFFEND, 1'b0, 8'd0);
        runCycles(4);

        $display("[TB] retarget mid-dead restarts interval");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        pushExp("rt_e0", S_OFFEND, G_OFFEND, 1'b0, 8'd0);
        pushExp("rt_e1", 3'd1, G_OFF, 1'b0, 8'd0);
        runCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
        pushExp("rt_e2", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("rt_e3", 3'd1, G_OFF, 1'b0, 8'd0);
        runCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd7);
        pushExp("rt_e4", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("rt_e5", 3'd1, G_OFF, 1'b0, 8'd0);
        pushExp("rt_e6", 3'd3, G_NEG, 1'b0, 8'd0);
        runCycles(3);

        $display("[TB] illegal command fault and clear");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        pushExp("ill_e0", 3'd3, G_NEG, 1'b0, 8'd0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        pushExp("ill_e1", 3'd5, G_OFF, 1'b1, 8'd1);
        pushExp("ill_hold", 3'd5, G_OFF, 1'b1, 8'd1);
        runCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
        pushExp("clr", 3'd0, G_OFF, 1'b0, 8'd1);
        runCycles(1);

        $display("[TB] fault persists through enable low and clear with bad command");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        pushExp("f2_e0", 3'd0, G_OFF, 1'b0, 8'd1);
        pushExp("f2_e1", 3'd5, G_OFF, 1'b1, 8'd2);
        runCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
        pushExp("f2_badclr", 3'd5, G_OFF, 1'b1, 8'd2);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        pushExp("f2_lag", 3'd5, G_OFF, 1'b1, 8'd2);
        pushExp("f2_clr", 3'd0, G_OFF, 1'b0, 8'd2);
        runCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        pushExp("f2_idle", 3'd0, G_OFF, 1'b0, 8'd2);
        runCycles(1);

        $display("[TB] fault_count saturation");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
            idleCycles(2);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
            idleCycles(2);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        pushExp("sat", 3'd0, G_OFF, 1'b0, 8'd255);
        runCycles(1);

        $display("[TB] async reset mid-dead");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
        pushExp("rs_e0", 3'd0, G_OFF, 1'b0, 8'd255);
        pushExp("rs_e1", 3'd1, G_OFF, 1'b0, 8'd255);
        pushExp("rs_e2", 3'd1, G_OFF, 1'b0, 8'd255);
        runCycles(3);
        #2 reset = 1'b1;
        #1;
        pushExp("rs_async", 3'd0, G_OFF, 1'b0, 8'd0);
        checkOutput();
        #1 reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        pushExp("rs_after", 3'd0, G_OFF, 1'b0, 8'd0);
        pushExp("rs_after", 3'd0, G_OFF, 1'b0, 8'd0);
        runCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
